// File: rtl/psum_collector.sv
// Purpose : de-skews the bottom-row partial-sum stream of an NxN systolic array into whole rows, with optional K-pass accumulation.
// Latency : a row is offered on row_o one cycle after its last element is written into the tile buffer.
// Backpressure: row_valid_o/row_o hold while row_ready_i is low; the full-tile buffer absorbs every column write during a stall.
module psum_collector #(
    parameter int N      = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       first_i,
    input  logic                       last_i,
    input  logic [N-1:0][DATA_W-1:0]   psum_i,
    input  logic [N-1:0]               acc_valid_i,
    output logic [N-1:0][DATA_W-1:0]   row_o,
    output logic [$clog2(N)-1:0]       row_idx_o,
    output logic                       row_valid_o,
    input  logic                       row_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int LW = $clog2(N);
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] N_C = CW'(N);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]        state_q;
    logic              first_q;
    logic              last_q;
    logic              err_q;
    logic              done_q;
    logic [CW-1:0]     out_ptr_q;
    logic [CW-1:0]     col_cnt_q [N];
    logic [DATA_W-1:0] tile_q [N][N];

    logic [N-1:0]      col_past_ptr;
    logic [N-1:0]      col_full;
    logic              row_hs;
    logic              pass_end;
    logic              collecting;
    logic              take_start;

    assign collecting = (state_q == S_COLLECT);
    assign take_start = start_i && (state_q != S_COLLECT);

    // Per-column status: has the column reached the row under the output pointer, and is it full.
    always_comb begin
        col_past_ptr = '0;
        col_full     = '0;
        for (int j = 0; j < N; j++) begin
            col_past_ptr[j] = (col_cnt_q[j] > out_ptr_q);
            col_full[j]     = (col_cnt_q[j] == N_C);
        end
    end

    assign row_valid_o = collecting && last_q && (out_ptr_q < N_C) && (&col_past_ptr);
    assign row_hs      = row_valid_o && row_ready_i;
    assign pass_end    = (&col_full) && (!last_q || (out_ptr_q == N_C));

    // Output row is read straight from the buffer; completed rows are never rewritten, so it is stable under stall.
    always_comb begin
        row_o = '0;
        for (int j = 0; j < N; j++) begin
            row_o[j] = tile_q[out_ptr_q[LW-1:0]][j];
        end
    end

    assign row_idx_o = out_ptr_q[LW-1:0];
    assign busy_o    = collecting;
    assign done_o    = done_q;
    assign err_o     = err_q;

    // Pass control: state, latched pass mode, per-column counters, output pointer, error and done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            out_ptr_q <= '0;
            for (int j = 0; j < N; j++) begin
                col_cnt_q[j] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (take_start) begin
                state_q   <= S_COLLECT;
                first_q   <= first_i;
                last_q    <= last_i;
                err_q     <= 1'b0;
                out_ptr_q <= '0;
                for (int j = 0; j < N; j++) begin
                    col_cnt_q[j] <= '0;
                end
            end else if (collecting) begin
                for (int j = 0; j < N; j++) begin
                    if (acc_valid_i[j]) begin
                        if (col_full[j]) begin
                            err_q <= 1'b1;
                        end else begin
                            col_cnt_q[j] <= col_cnt_q[j] + 1'b1;
                        end
                    end
                end
                if (row_hs) begin
                    out_ptr_q <= out_ptr_q + 1'b1;
                end
                if (pass_end) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    // Tile buffer: each strobing column writes (or accumulates into) the row its counter points at.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) begin
                    tile_q[r][j] <= '0;
                end
            end
        end else if (collecting) begin
            for (int j = 0; j < N; j++) begin
                if (acc_valid_i[j] && !col_full[j]) begin
                    tile_q[col_cnt_q[j][LW-1:0]][j] <=
                        (first_q ? '0 : tile_q[col_cnt_q[j][LW-1:0]][j]) + psum_i[j];
                end
            end
        end
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Consumes the skewed partial-sum stream leaving the bottom row of the N×N systolic array.
- Column j emits its N results staggered in time, qualified by the per-column accumulator-valid strobes from the array controller.
- Buffers one N×N output tile and de-skews it into whole rows.
- Optionally accumulates across multiple passes (K-tiling), then drains completed rows over a valid/ready interface to the writeback path.

Parameters:
- N, 4, array dimension (columns per row, rows per tile).
- DATA_W, 32, partial-sum and accumulator width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  begin a pass; sampled only in S_IDLE/S_DONE.
- first_i  in  1  sampled with start_i; 1 = overwrite buffer, 0 = add to buffer.
- last_i  in  1  sampled with start_i; 1 = emit rows this pass.
- psum_i  in  N×DATA_W  bottom-row partial sums, one per column.
- acc_valid_i  in  N  per-column strobe; psum_i[j] valid when bit j is high.
- row_o  out  N×DATA_W  completed output row.
- row_idx_o  out  log2(N)  index of row on row_o.
- row_valid_o  out  1  row_o/row_idx_o valid.
- row_ready_i  in  1  downstream accepts row.
- busy_o  out  1  pass in progress.
- done_o  out  1  one-cycle pulse at pass completion.
- err_o  out  1  sticky overflow flag.

Behaviour:
- Reset (async, rst_ni low):
  - state=S_IDLE; all col_cnt[j]=0; out_ptr=0; buffer cleared to 0.
  - Latched first/last = 0.
  - Outputs: row_valid_o=0, busy_o=0, done_o=0, err_o=0, row_idx_o=0.
  - Reset mid-pass aborts the pass; no rows emitted afterwards.
- States: S_IDLE, S_COLLECT, S_DONE.
- S_IDLE/S_DONE:
  - start_i=1 → S_COLLECT next cycle.
  - Latch first_i/last_i; clear col_cnt, out_ptr, err_o.
  - busy_o=1 from the following cycle.
  - In S_COLLECT, start_i is ignored.
- S_COLLECT write, per column j, each cycle acc_valid_i[j]=1 and col_cnt[j]<N:
  - buf[col_cnt[j]][j] <= (first ? 0 : buf[col_cnt[j]][j]) + psum_i[j].
  - Addition wraps modulo 2^DATA_W.
  - col_cnt[j]++.
  - Columns are fully independent; any subset may strobe in the same cycle.
- Overflow: acc_valid_i[j]=1 with col_cnt[j]==N → data dropped, err_o set (sticky until next start).
- acc_valid_i outside S_COLLECT: ignored; no error.
- Row completion: row r is complete when col_cnt[j]>r for all j.
- Emission, only when last=1:
  - row_valid_o = S_COLLECT && out_ptr<N && row out_ptr complete.
  - row_valid_o rises the cycle after the final element of the row is written (1-cycle latency).
  - row_o = buf[out_ptr]; row_idx_o = out_ptr.
  - Stable while row_valid_o && !row_ready_i. A completed row is never rewritten within the pass.
  - Handshake (valid && ready) → out_ptr++.
  - Rows are emitted strictly in order 0..N-1.
  - A row completing while the previous row is stalled waits its turn; no loss, since the buffer holds the whole tile.
- Transition to S_DONE:
  - last=0: all col_cnt==N.
  - last=1: all col_cnt==N and out_ptr==N.
  - done_o pulses 1 cycle on entry; busy_o=0 in S_DONE.
  - Buffer contents retained for the next accumulating pass.
- start_i coinciding with the S_COLLECT→S_DONE transition cycle: ignored. It must be reasserted in S_DONE.

Test Plan (N=4, DATA_W=32):
- Single pass, first=1, last=1, ready=1:
  - Stimulus: column j strobes at cycles t0+j..t0+j+3 with psum=10*r+j.
  - Required: 4 rows; row 0 = {0,1,2,3} valid the cycle after column 3's first write; row 3 = {30,31,32,33}; done_o pulses once.
- Accumulation:
  - Stimulus: pass 1 (first=1, last=0) all psums=5; pass 2 (first=0, last=1) all psums=7.
  - Required: no rows in pass 1; every element =12 in pass 2.
- Backpressure:
  - Stimulus: row_ready_i=0 until all columns have finished, then ready=1.
  - Required: row 0 held stable throughout; rows 0..3 then emitted on 4 consecutive cycles; done_o after the 4th handshake.
- Overflow:
  - Stimulus: a 5th strobe on column 2.
  - Required: err_o=1, buffer unchanged, remaining rows correct.
- Wrap:
  - Stimulus: pass with first=0, buffer=0xFFFF_FFFF, psum=2.
  - Required: element = 0x0000_0001.
- Reset mid-pass:
  - Stimulus: rst_ni low after 2 writes per column.
  - Required: all outputs 0 immediately; a new start gives a clean tile.
